// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready byte stream that carries program words into
// the instruction-store loader. The producer (host or bench) uses the
// master modport; the loader uses the slave modport.
interface imem_loader_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writer end of the instruction-fetch store. Streams a program
// of load_len bytes into a 64 x 8 register-based store at sequential
// addresses, holds the core in reset while loading, and releases it once the
// whole program is in place. A combinational read port serves the fetch stage.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- after the program words
// one extra checksum byte is accepted; the load succeeds only if the 8-bit
// sum of all words plus the checksum byte is zero, otherwise the FSM enters ERR.
module imem_loader #(
  parameter int DW    = 8,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  imem_loader_if.slave  s_in,
  input  logic [7:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          core_reset_n,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   wr_ptr
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ERR} state_t;
`endif

  state_t        state_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   len_q;
  logic [AW:0]   wr_ptr_q;
  logic          in_ready_q;
  logic          core_reset_n_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [AW:0]   wr_ptr_d;
  logic          accept;
  logic          len_legal;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_q;
  logic [DW-1:0] sum_d;
`endif

  // Handshake qualification and next-pointer / running-sum arithmetic.
  always_comb begin
    accept    = s_in.in_valid & in_ready_q;
    len_legal = (load_len != '0) && (load_len <= DEPTH_W);
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q + s_in.in_data;
`endif
  end

  // Loader FSM with registered outputs; also owns the store's write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      wr_ptr_q       <= '0;
      in_ready_q     <= 1'b0;
      core_reset_n_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q          <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        // IDLE, RUN and ERR all start a new load on a legal load_start;
        // an illegal length only raises the sticky error flag.
        S_IDLE, S_RUN, S_ERR: begin
          if (load_start) begin
            if (len_legal) begin
              state_q        <= S_LOAD;
              len_q          <= load_len;
              wr_ptr_q       <= '0;
              in_ready_q     <= 1'b1;
              core_reset_n_q <= 1'b0;
              busy_q         <= 1'b1;
              done_q         <= 1'b0;
              err_q          <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum_q          <= '0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        // Write accepted words; the last word lands on the same edge that
        // leaves LOAD, so the core is released only after it is stored.
        S_LOAD: begin
          if (accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_in.in_data;
            wr_ptr_q                <= wr_ptr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q                   <= sum_d;
            if (wr_ptr_d == len_q) state_q <= S_CHECK;
`else
            if (wr_ptr_d == len_q) begin
              state_q        <= S_RUN;
              in_ready_q     <= 1'b0;
              busy_q         <= 1'b0;
              done_q         <= 1'b1;
              core_reset_n_q <= 1'b1;
            end
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        // One checksum byte: never stored, never advances wr_ptr.
        S_CHECK: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (sum_d == '0) begin
              state_q        <= S_RUN;
              done_q         <= 1'b1;
              core_reset_n_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_in.in_ready = in_ready_q;
  assign core_reset_n  = core_reset_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign wr_ptr        = wr_ptr_q;

  // Fetch read port: PC wraps modulo DEPTH; a same-cycle write is seen next cycle.
  assign rd_data = mem_q[rd_addr[AW-1:0]];

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test of the instruction-store loader with
// hand-computed expected values checked by immediate assertions.
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic [6:0] load_len;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       core_reset_n, busy, done, err;
  logic [6:0] wr_ptr;
  logic [7:0] prog [64];
  int         errors = 0;
  int         checks = 0;

  imem_loader_if #(.DW(8)) bus ();

  imem_loader #(.DW(8), .AW(6), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .s_in(bus.slave), .rd_addr(rd_addr), .rd_data(rd_data),
    .core_reset_n(core_reset_n), .busy(busy), .done(done), .err(err),
    .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [6:0] len);
    load_start = 1'b1;
    load_len   = len;
    step();
    load_start = 1'b0;
  endtask

  // Stream prog[0..n-1] with in_valid held high; in_ready must be up every beat.
  task automatic stream_raw(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = prog[i];
      chk($sformatf("in_ready_beat%0d", i), bus.in_ready, 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  // Checksum beat that makes the load succeed (only exists with the feature).
  task automatic send_csum(input int n);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++) s = s + prog[i];
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00 - s;
    step();
    bus.in_valid = 1'b0;
`endif
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic set4();
    prog[0] = 8'h41; prog[1] = 8'h42; prog[2] = 8'hC0; prog[3] = 8'h07;
  endtask

  initial begin
    reset = 1'b0; load_start = 1'b0; load_len = '0; rd_addr = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    set4();
    #12;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_core_reset_n", core_reset_n, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_wr_ptr", wr_ptr, 7'd0);
    read_chk("rst_mem0", 8'd0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Test 1: 4-word load, valid held high.
    start(7'd4);
    chk("t1_busy", busy, 1'b1);
    chk("t1_wr_ptr0", wr_ptr, 7'd0);
    stream_raw(3);
    chk("t1_core_held", core_reset_n, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = prog[3];
    step();
    bus.in_data = 8'hFF;           // extra beat after completion
    send_csum(4);
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    step();
    bus.in_valid = 1'b0;
    chk("t1_core_rel", core_reset_n, 1'b1);
    chk("t1_done", done, 1'b1);
    chk("t1_in_ready0", bus.in_ready, 1'b0);
    chk("t1_wr_ptr4", wr_ptr, 7'd4);
    read_chk("t1_mem0", 8'd0, 8'h41);
    read_chk("t1_mem1", 8'd1, 8'h42);
    read_chk("t1_mem2", 8'd2, 8'hC0);
    read_chk("t1_mem3", 8'd3, 8'h07);
    read_chk("t1_mem4", 8'd4, 8'h00);
    read_chk("t1_wrap66", 8'd66, 8'hC0);

    // Test 2: same load from a fresh reset with in_valid toggling.
    reset = 1'b0; #2; reset = 1'b1;
    read_chk("t2_cleared", 8'd2, 8'h00);
    step();
    start(7'd4);
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (c % 2 == 0);
      bus.in_data  = (c % 2 == 0) ? prog[c/2] : 8'hEE;
      step();
      chk($sformatf("t2_wr_ptr_c%0d", c), wr_ptr, 7'(c/2 + 1));
    end
    bus.in_valid = 1'b0;
    send_csum(4);
    chk("t2_done", done, 1'b1);
    read_chk("t2_mem0", 8'd0, 8'h41);
    read_chk("t2_mem1", 8'd1, 8'h42);
    read_chk("t2_mem2", 8'd2, 8'hC0);
    read_chk("t2_mem3", 8'd3, 8'h07);

    // Test 3: illegal lengths from IDLE, then a legal start clears err.
    reset = 1'b0; #2; reset = 1'b1;
    step();
    start(7'd0);
    chk("t3_err_len0", err, 1'b1);
    chk("t3_busy_len0", busy, 1'b0);
    chk("t3_rdy_len0", bus.in_ready, 1'b0);
    reset = 1'b0; #2; reset = 1'b1;
    step();
    start(7'd65);
    chk("t3_err_len65", err, 1'b1);
    chk("t3_busy_len65", busy, 1'b0);
    chk("t3_rdy_len65", bus.in_ready, 1'b0);
    start(7'd4);
    chk("t3_err_clr", err, 1'b0);
    chk("t3_busy_legal", busy, 1'b1);
    stream_raw(4);
    send_csum(4);
    chk("t3_done", done, 1'b1);

    // Test 4: reload 2 words while running.
    load_start = 1'b1; load_len = 7'd2;
    step();
    load_start = 1'b0;
    chk("t4_core_drop", core_reset_n, 1'b0);
    chk("t4_done_drop", done, 1'b0);
    prog[0] = 8'h11; prog[1] = 8'h22;
    stream_raw(1);
    chk("t4_core_held", core_reset_n, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = prog[1];
    step();
    bus.in_valid = 1'b0;
    send_csum(2);
    chk("t4_core_rel", core_reset_n, 1'b1);
    read_chk("t4_mem0", 8'd0, 8'h11);
    read_chk("t4_mem1", 8'd1, 8'h22);
    read_chk("t4_mem2", 8'd2, 8'hC0);
    read_chk("t4_mem3", 8'd3, 8'h07);

    // Test 5: asynchronous reset mid-load after 2 of 4 words.
    set4();
    start(7'd4);
    stream_raw(2);
    chk("t5_wr_ptr2", wr_ptr, 7'd2);
    reset = 1'b0;
    #1;
    chk("t5_in_ready", bus.in_ready, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_wr_ptr", wr_ptr, 7'd0);
    chk("t5_core", core_reset_n, 1'b0);
    for (int a = 0; a < 4; a++) read_chk($sformatf("t5_mem%0d", a), 8'(a), 8'h00);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Test 6: full-depth load (len = 64).
    for (int i = 0; i < 64; i++) prog[i] = 8'(i * 3 + 1);
    start(7'd64);
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1; bus.in_data = prog[i];
      step();
    end
    bus.in_valid = 1'b0;
    chk("t6_wr_ptr64", wr_ptr, 7'd64);
    send_csum(64);
    chk("t6_done", done, 1'b1);
    read_chk("t6_mem63", 8'd63, 8'd190);
    read_chk("t6_mem0_wrap", 8'd128, 8'h01);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Test 7: checksum good (FA) then bad (FB).
    prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03; prog[3] = 8'hFA;
    start(7'd3);
    stream_raw(4);
    chk("t7_good_done", done, 1'b1);
    chk("t7_good_err", err, 1'b0);
    chk("t7_good_wr_ptr", wr_ptr, 7'd3);
    read_chk("t7_mem3_kept", 8'd3, 8'd10);
    prog[3] = 8'hFB;
    start(7'd3);
    stream_raw(4);
    chk("t7_bad_err", err, 1'b1);
    chk("t7_bad_core", core_reset_n, 1'b0);
    chk("t7_bad_done", done, 1'b0);
    chk("t7_bad_rdy", bus.in_ready, 1'b0);
    start(7'd1);
    chk("t7_err_exit", err, 1'b0);
    chk("t7_err_busy", busy, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer end of the instruction-fetch interface: fills the 64-word × 8-bit instruction store that the fetch stage reads.
- Program bytes arrive over a valid/ready stream and are written at sequential addresses.
- The core is held in reset while loading and released when the program is complete.
- Provides the combinational read port the fetch stage uses (PC in, instruction code out).

Parameters:
- DW, 8, instruction word width (opcode [7:6], operand [5:0]).
- AW, 6, address width; matches the 6-bit jump address field.
- DEPTH, 64, number of words; must equal 2**AW.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_start  input  1  one-cycle pulse: begin loading a program of load_len words.
- load_len  input  AW+1  word count, legal range 1..DEPTH; sampled only when load_start is accepted.
- in_data  input  DW  program byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- rd_addr  input  8  PC from fetch; only [AW-1:0] is used.
- rd_data  output  DW  instruction at rd_addr (combinational).
- core_reset_n  output  1  0 = hold the core in reset.
- busy  output  1  high in LOAD/CHECK.
- done  output  1  high in RUN.
- err  output  1  sticky error flag.
- wr_ptr  output  AW+1  number of words written in the current load.

Behaviour:
- States: IDLE, LOAD, CHECK (only with the optional feature), RUN, ERR. Encoded state register, asynchronous reset to IDLE.
- Reset (reset=0):
  - state=IDLE, in_ready=0, core_reset_n=0, busy=0, done=0, err=0, wr_ptr=0.
  - All memory words = 8'h00.
  - Reset mid-load abandons the load; words already written are cleared to 0.
- Accepted word: in_valid & in_ready in the same cycle. Write mem[wr_ptr[AW-1:0]] = in_data; wr_ptr increments.
- in_ready = 1 only in LOAD and CHECK. Registered and combinational in_ready are both allowed, but no word may be accepted outside those states.
- IDLE:
  - load_start with 1 ≤ load_len ≤ DEPTH: latch len, wr_ptr←0, go to LOAD.
  - load_start with load_len = 0 or > DEPTH: err←1, stay IDLE.
- LOAD:
  - When an accepted word makes wr_ptr == len, go to RUN the next edge (or to CHECK with the feature). The final word is written on that same edge.
  - load_start while in LOAD is ignored.
- RUN:
  - core_reset_n=1, done=1. It rises on the edge after the last word is written, so the core never fetches a half-written program.
  - load_start: core_reset_n←0 on the same edge, latch new len, wr_ptr←0, err←0, go to LOAD.
  - Words at addresses ≥ the new len keep their previous contents.
- ERR: core_reset_n=0, err=1. Only load_start (legal len) exits, to LOAD, clearing err. A reset also exits.
- err clears on any accepted legal load_start.
- Read port:
  - rd_data = mem[rd_addr[AW-1:0]], combinational, available in all states.
  - PC values ≥ 64 wrap modulo 64.
  - A read and a write to the same address in the same cycle returns the old word.
- wr_ptr never exceeds len; extra in_valid beats after completion are not accepted (in_ready=0).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After len words, the FSM enters CHECK and accepts exactly one extra checksum byte. This byte is not written to memory and does not advance wr_ptr.
  - A running 8-bit sum of all program words (modulo 256) is kept, cleared on load_start.
  - If (sum + checksum_byte) mod 256 == 0, go to RUN; otherwise go to ERR.
- Disabled:
  - No CHECK state and no sum register.
  - LOAD goes straight to RUN after the last word.

Test Plan:
- Reset release, then load_start with load_len=4 and stream 8'h41,8'h42,8'hC0,8'h07 with in_valid held high → in_ready=1 for four cycles; mem[0..3] hold those values; core_reset_n rises the cycle after the 4th accept; done=1; rd_addr=2 gives rd_data=8'hC0.
- Same load with in_valid toggling 1,0,1,0 → only valid beats are written; wr_ptr steps 0→1→1→2…; the final memory contents are identical to the previous test.
- load_start with load_len=0, then separately with load_len=65 → err=1, state stays IDLE, in_ready=0. A following legal load_start clears err.
- In RUN after a 4-word load, load_start with load_len=2 and data 8'h11,8'h22 → core_reset_n drops on the start edge; mem[0..1] = 11,22; mem[2..3] still C0,07; core_reset_n rises again after the 2nd word.
- Assert reset low mid-load after 2 of 4 words → all outputs return to reset values immediately; rd_data=8'h00 at every address.
- With IMEM_LOADER_CHECKSUM_EN: words 01,02,03 followed by checksum FA → RUN. Repeat with checksum FB → ERR with err=1 and core_reset_n=0.
